// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes, data-memory wait with timeout, external halt.
// Optional stall statistics counter (stall_cnt_out) is built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
  parameter int INDEX = 5,
  parameter int TMO_W = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             idex_mem_read_in,
  input  logic [INDEX-1:0] idex_rd_in,
  input  logic [INDEX-1:0] ifid_rs1_in,
  input  logic [INDEX-1:0] ifid_rs2_in,
  input  logic             branch_taken_in,
  input  logic             dmem_req_in,
  input  logic             dmem_ready_in,
  input  logic             halt_in,
  input  logic             resume_in,
  output logic             pc_write_out,
  output logic             ifid_write_out,
  output logic             idex_write_out,
  output logic             exmem_write_out,
  output logic             ifid_flush_out,
  output logic             idex_flush_out,
  output logic             exmem_flush_out,
  output logic             memwb_flush_out,
  output logic             halted_out,
  output logic             timeout_out
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_out
`endif
);

  // state    | meaning
  // INIT     | one-cycle flush of every stage register after reset/resume
  // RUN      | normal flow; load-use stall and branch flush applied here
  // MEM_WAIT | all stages frozen until data memory is ready or timeout
  // HALT     | frozen until resume_in (without halt_in)
  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIMIT = '1;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
  logic             load_use;

  assign load_use = idex_mem_read_in && (idex_rd_in != '0) &&
                    ((idex_rd_in == ifid_rs1_in) || (idex_rd_in == ifid_rs2_in));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_INIT;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tmo_cnt_d       = tmo_cnt_q;
    timeout_d       = timeout_q;
    pc_write_out    = 1'b0;
    ifid_write_out  = 1'b0;
    idex_write_out  = 1'b0;
    exmem_write_out = 1'b0;
    ifid_flush_out  = 1'b0;
    idex_flush_out  = 1'b0;
    exmem_flush_out = 1'b0;
    memwb_flush_out = 1'b0;
    halted_out      = 1'b0;

    case (state_q)
      ST_INIT: begin
        ifid_flush_out  = 1'b1;
        idex_flush_out  = 1'b1;
        exmem_flush_out = 1'b1;
        memwb_flush_out = 1'b1;
        tmo_cnt_d       = '0;
        state_d         = ST_RUN;
      end

      ST_RUN: begin
        if (halt_in) begin
          memwb_flush_out = 1'b1;
          state_d         = ST_HALT;
        end else if (dmem_req_in && !dmem_ready_in) begin
          memwb_flush_out = 1'b1;
          tmo_cnt_d       = TMO_W'(1);
          state_d         = ST_MEM_WAIT;
        end else begin
          pc_write_out    = 1'b1;
          ifid_write_out  = 1'b1;
          idex_write_out  = 1'b1;
          exmem_write_out = 1'b1;
          // A taken branch squashes the dependent instruction, so no stall is needed.
          if (branch_taken_in) begin
            ifid_flush_out = 1'b1;
            idex_flush_out = 1'b1;
          end else if (load_use) begin
            pc_write_out   = 1'b0;
            ifid_write_out = 1'b0;
            idex_flush_out = 1'b1;
          end
        end
      end

      ST_MEM_WAIT: begin
        if (halt_in) begin
          memwb_flush_out = 1'b1;
          state_d         = ST_HALT;
        end else if (dmem_ready_in) begin
          pc_write_out    = 1'b1;
          ifid_write_out  = 1'b1;
          idex_write_out  = 1'b1;
          exmem_write_out = 1'b1;
          state_d         = ST_RUN;
        end else begin
          memwb_flush_out = 1'b1;
          // The stall cycle in RUN counted as wait cycle 1, so the limit is hit one increment early.
          if (tmo_cnt_q >= TMO_LIMIT - 1'b1) begin
            tmo_cnt_d = TMO_LIMIT;
            timeout_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end

      ST_HALT: begin
        memwb_flush_out = 1'b1;
        halted_out      = 1'b1;
        if (resume_in && !halt_in) begin
          timeout_d = 1'b0;
          state_d   = ST_INIT;
        end
      end

      default: begin
        ifid_flush_out  = 1'b1;
        idex_flush_out  = 1'b1;
        exmem_flush_out = 1'b1;
        memwb_flush_out = 1'b1;
        state_d         = ST_INIT;
      end
    endcase
  end

  assign timeout_out = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ST_INIT) && !pc_write_out && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter INDEX, default 5: register-index width.
REQ-002 Parameter TMO_W, default 8: memory-wait timeout counter width; timeout limit = 2^TMO_W-1 cycles.
REQ-003 Parameter CNT_W, default 32: stall-statistics counter width.
REQ-004 clk_in  input  1  clock, rising-edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-low.
REQ-006 idex_mem_read_in  input  1  instruction in EX is a load.
REQ-007 idex_rd_in  input  INDEX  destination register of EX instruction.
REQ-008 ifid_rs1_in, ifid_rs2_in  input  INDEX each  source registers of ID instruction.
REQ-009 branch_taken_in  input  1  EX resolved a taken branch/jump.
REQ-010 dmem_req_in  input  1  MEM stage issues a data-memory access.
REQ-011 dmem_ready_in  input  1  data memory completes the access this cycle.
REQ-012 halt_in, resume_in  input  1 each  external halt request / release.
REQ-013 pc_write_out, ifid_write_out, idex_write_out, exmem_write_out  output  1 each  stage-register load enables.
REQ-014 ifid_flush_out, idex_flush_out, exmem_flush_out, memwb_flush_out  output  1 each  stage-register flushes (bubble insert).
REQ-015 halted_out  output  1  controller in HALT.
REQ-016 timeout_out  output  1  sticky: memory wait exceeded limit.

Function
REQ-017 FSM states SHALL be INIT, RUN, MEM_WAIT, HALT; outputs are combinational from state and current inputs.
REQ-018 INIT: all write enables 0, all flushes 1; next state RUN unconditionally (exactly one cycle).
REQ-019 RUN default: all write enables 1, all flushes 0.
REQ-020 Load-use hazard = idex_mem_read_in & idex_rd_in!=0 & (idex_rd_in==ifid_rs1_in | idex_rd_in==ifid_rs2_in); in RUN SHALL drive pc_write=0, ifid_write=0, idex_flush=1 for that cycle only.
REQ-021 In RUN, branch_taken_in SHALL drive ifid_flush=1, idex_flush=1, pc_write=1, and override load-use.
REQ-022 In RUN, dmem_req_in & !dmem_ready_in SHALL freeze all stages (all writes 0, memwb_flush=1, other flushes 0), override branch and load-use, and transition to MEM_WAIT; timeout counter loads 1.
REQ-023 MEM_WAIT: same freeze outputs; on dmem_ready_in outputs are RUN-default for that cycle and next state RUN.
REQ-024 MEM_WAIT counter increments each non-ready cycle; on reaching 2^TMO_W-1 without ready, set timeout_out and go to HALT.
REQ-025 halt_in in RUN or MEM_WAIT SHALL take priority over all other events; next state HALT; current cycle uses freeze outputs.
REQ-026 HALT: all writes 0, memwb_flush=1, halted_out=1; resume_in with halt_in low SHALL go to INIT; halt_in and resume_in both high stays HALT.
REQ-027 timeout_out SHALL clear only on reset or on leaving HALT via resume_in.
REQ-028 Simultaneous dmem_req_in & dmem_ready_in in RUN SHALL not stall.

Reset
REQ-029 rst_in low SHALL force state INIT, counter 0, timeout_out 0, halted_out 0, immediately regardless of clock.
REQ-030 While rst_in low outputs SHALL equal INIT outputs (writes 0, flushes 1); reset mid-MEM_WAIT or mid-HALT discards state.

Configuration
REQ-031 Macro PIPE_CTRL_PERF_EN defined: add output stall_cnt_out (CNT_W), counting cycles with pc_write_out=0 outside INIT, saturating at all-ones, reset 0.
REQ-032 Macro undefined: stall_cnt_out port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 idex_mem_read=1, idex_rd=5, ifid_rs1=5 in RUN -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle RUN defaults.
REQ-034 Same as REQ-033 with idex_rd=0 -> no stall.
REQ-035 branch_taken=1 with concurrent load-use -> ifid_flush=1, idex_flush=1, pc_write=1.
REQ-036 dmem_req=1, dmem_ready low 3 cycles then high -> 3 freeze cycles with memwb_flush=1, then RUN; stall_cnt_out=3 if PERF_EN.
REQ-037 TMO_W=4, dmem_ready never high -> HALT after 15 wait cycles, timeout_out=1; resume_in -> INIT one cycle then RUN, timeout_out=0.
REQ-038 rst_in low asynchronously mid-MEM_WAIT -> outputs immediately INIT values; after release one INIT cycle then RUN.
